// File: rtl/mmix_defs.sv
// mmix_defs: shared arbiter state encoding and memory access size codes
package mmix_defs;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] WYDE = 2'd1;
  localparam logic [1:0] TETRA = 2'd2;
  localparam logic [1:0] OCTA = 2'd3;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotating-start priority encoder choosing one requester
module rr_picker #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input logic [N-1:0] req,
  input logic [IW-1:0] start,
  input logic mode,
  output logic [IW-1:0] winner,
  output logic valid
);
  int base;
  int best;
  always_comb begin
    base = mode ? int'(start) : 0;
    best = N;
    winner = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (req[k] && ((k + N - base) % N) < best) begin
        best = (k + N - base) % N;
        winner = IW'(k);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: multi-port memory arbiter with round-robin/fixed priority and optional timeout
module mem_arbiter
  import mmix_defs::*;
#(
  parameter int NPORTS = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic reset_n,
  input logic [NPORTS-1:0][ADDR_W-1:0] p_address,
  input logic [NPORTS-1:0][1:0] p_datasize,
  input logic [NPORTS-1:0] p_read,
  input logic [NPORTS-1:0] p_write,
  input logic [NPORTS-1:0][DATA_W-1:0] p_writedata,
  output logic [DATA_W-1:0] p_readdata,
  output logic [NPORTS-1:0] p_done,
  output logic [NPORTS-1:0] p_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0] mem_datasize,
  output logic mem_read,
  output logic mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input logic [DATA_W-1:0] mem_readdata,
  input logic mem_done,
  output logic busy,
  output logic [$clog2(NPORTS)-1:0] grant_id
);
  localparam int IW = $clog2(NPORTS);
  arb_state_t state, next_state;
  logic [IW-1:0] last_grant, start, winner;
  logic valid, conflict, expired;
  logic [31:0] timer;
  rr_picker #(.N(NPORTS), .IW(IW)) u_picker (
    .req(p_read | p_write),
    .start(start),
    .mode(RR_MODE != 0),
    .winner(winner),
    .valid(valid)
  );
  assign busy = state == BUSY;
  always_comb begin
    start = (last_grant == IW'(NPORTS - 1)) ? '0 : last_grant + IW'(1);
    conflict = p_read[winner] & p_write[winner];
    expired = (TIMEOUT > 0) && (timer == 32'(TIMEOUT - 1));
    next_state = (state == IDLE) ? (valid ? (conflict ? DONE : BUSY) : IDLE)
               : (state == BUSY) ? ((mem_done || expired) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_grant <= IW'(NPORTS - 1);
      grant_id <= '0;
      timer <= '0;
      p_done <= '0;
      p_error <= '0;
      p_readdata <= '0;
      mem_address <= '0;
      mem_datasize <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_writedata <= '0;
    end else begin
      p_done <= '0;
      p_error <= '0;
      if (state == IDLE && valid) begin
        grant_id <= winner;
        last_grant <= winner;
        timer <= '0;
        if (conflict) p_error[winner] <= 1'b1;
        else begin
          mem_address <= p_address[winner];
          mem_datasize <= p_datasize[winner];
          mem_writedata <= p_writedata[winner];
          mem_read <= p_read[winner];
          mem_write <= p_write[winner];
        end
      end
      if (state == BUSY) begin
        timer <= timer + 32'd1;
        if (mem_done || expired) begin
          mem_read <= 1'b0;
          mem_write <= 1'b0;
          if (mem_done) begin
            p_done[grant_id] <= 1'b1;
            if (mem_read) p_readdata <= mem_readdata;
          end else p_error[grant_id] <= 1'b1;
        end
      end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NPORTS, default 2: number of requesting masters, 2..8.
REQ-002 Parameter ADDR_W, default 64: address width.
REQ-003 Parameter DATA_W, default 64: data width.
REQ-004 Parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority (port 0 highest).
REQ-005 Parameter TIMEOUT, default 0: BUSY-cycle limit; 0 = disabled.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 p_address  in  NPORTS x ADDR_W  per-port address.
REQ-009 p_datasize  in  NPORTS x 2  per-port size: 0 byte, 1 wyde, 2 tetra, 3 octa.
REQ-010 p_read / p_write  in  NPORTS each  per-port request strobes, held until done or error.
REQ-011 p_writedata  in  NPORTS x DATA_W  per-port store data.
REQ-012 p_readdata  out  DATA_W  registered load data, shared by all ports.
REQ-013 p_done / p_error  out  NPORTS each  one-cycle completion / failure pulses.
REQ-014 mem_address, mem_datasize, mem_read, mem_write, mem_writedata  out  memory-side request, registered.
REQ-015 mem_readdata  in  DATA_W; mem_done  in  1  memory completion pulse.
REQ-016 busy  out  1; grant_id  out  $clog2(NPORTS)  current owner.

Function
REQ-017 FSM states: IDLE, BUSY, DONE.
REQ-018 IDLE: a port is requesting when p_read|p_write is high; the winner is chosen per RR_MODE, and request fields are latched into internal registers.
REQ-019 Round-robin: search starts at last_grant+1 mod NPORTS and wraps past NPORTS-1 to 0.
REQ-020 Fixed priority: the lowest requesting index wins.
REQ-021 IDLE with a valid winner -> BUSY next cycle; mem_read/mem_write are asserted from latched copies starting that cycle; busy=1.
REQ-022 Port with p_read&p_write both high wins normally, but goes IDLE->DONE with p_error pulse; no memory access.
REQ-023 BUSY holds mem_* constant; p_* changes on the granted port are ignored until DONE.
REQ-024 BUSY with mem_done=1: capture mem_readdata into p_readdata, deassert mem_read/mem_write next cycle, pulse p_done[grant_id] next cycle, -> DONE.
REQ-025 Latency: request sampled in cycle 0 -> mem strobe in cycle 1 -> mem_done in cycle k -> p_done in cycle k+1.
REQ-026 TIMEOUT>0: TIMEOUT consecutive BUSY cycles without mem_done -> drop strobes, pulse p_error[grant_id], -> DONE; mem_done arriving on the same cycle wins over timeout.
REQ-027 DONE lasts exactly one cycle (the granted master deasserts its request); the granted port is excluded from arbitration that cycle; -> IDLE.
REQ-028 last_grant updates only on entry to BUSY or error-DONE.
REQ-029 mem_done outside BUSY is ignored.
REQ-030 p_readdata holds its value until the next successful read.
REQ-031 At most one port is active at a time; p_done and p_error are never both high.

Reset
REQ-032 reset_n low: state=IDLE, all mem_* outputs, p_done, p_error, busy, grant_id and p_readdata = 0, immediately and asynchronously.
REQ-033 last_grant resets to NPORTS-1 so port 0 wins first.
REQ-034 Reset mid-BUSY aborts the transaction silently; no done or error pulse is issued.

Structure
REQ-035 The arb state enum and the datasize constants (BYTE, WYDE, TETRA, OCTA) belong in the shared mmix_defs package.
REQ-036 The rotating-start priority encoder is one combinational sub-module, rr_picker (inputs: req vector, start index, mode; output: winner and valid).
REQ-037 Target size is 120-400 RTL lines.

Verification
REQ-038 Port 1 reads 0x8000_0000_0000_0100, size 3; memory done after 3 cycles with 0x0123456789ABCDEF -> mem_read high cycles 1..3, p_done[1] in cycle 4, p_readdata=0x0123456789ABCDEF.
REQ-039 RR_MODE=1, NPORTS=4, all ports request continuously, 1-cycle memory -> grants 0,1,2,3,0.
REQ-040 RR_MODE=0, ports 0 and 2 request continuously -> port 0 always wins; port 2 starves.
REQ-041 TIMEOUT=8, memory never responds -> strobes drop after 8 BUSY cycles, p_error pulse, next request is served normally.
REQ-042 Port 0 asserts read and write together -> p_error[0] in cycle 1, mem_read=mem_write=0 throughout.
REQ-043 reset_n low in cycle 2 of a write, then mem_done arrives -> mem_write drops immediately, no p_done, state IDLE, port 0 granted first after release.
